aes128_key_schedule: RTL and testbench

Iterative AES-128 key expansion engine that produces round keys 0..10 one round at a time, on demand from the round controller's ADD_ROUND_KEY step. It holds the current 128-bit round key and the current Rcon. Each advance takes one byte-serial S-box lookup of the rotated last word, then one combine cycle. It sits directly upstream of the round XOR and replaces feeding the raw cipher key every round.

---
 rtl/aes128_type_pkg.sv | 40 ++++
 rtl/aes128_sbox.sv | 14 +
 rtl/aes128_key_schedule.sv | 121 ++++++++++++
 tb/tb_aes128_key_schedule.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/aes128_type_pkg.sv
// Shared AES-128 types and constants: S-box table, Rcon seed, round count, key-schedule states.
// Latency: n/a (constants, types and a pure combinational helper).
// Backpressure: n/a.
package aes128_type_pkg;

    localparam int         AES128_NUM_ROUNDS = 10;
    localparam logic [7:0] RCON_INIT         = 8'h01;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SUB    = 2'd1,
        EXPAND = 2'd2
    } ks_state_t;

    // Forward S-box, indexed by the input byte.
    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Multiply by x in GF(2^8) modulo the AES polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes128_sbox.sv
// AES forward S-box byte lookup; shared by key schedule and byte-serial SubBytes stage.
// Latency: combinational.
// Backpressure: none (pure function of in_byte).
// Ports: in_byte - byte to substitute; out_byte - substituted byte.
module aes128_sbox
    import aes128_type_pkg::*;
(
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    assign out_byte = SBOX[in_byte];

endmodule

// File: rtl/aes128_key_schedule.sv
// Iterative AES-128 key expansion: holds the current round key and advances it by one round per request.
// Latency: done_o pulses 6 edges after next_i is accepted (4 S-box cycles, 1 combine, 1 output cycle).
// Backpressure: next_i is ignored while busy_o or at the last round; load_i always wins and aborts.
// Ports: clk_i/rst_n_i clock and async active-low reset; load_i/key_i load round key 0;
//        next_i requests the next round key; round_key_o/round_o current key and its index;
//        busy_o expansion in flight; done_o one-cycle pulse when a new round key is valid.
module aes128_key_schedule
    import aes128_type_pkg::*;
#(
    parameter int NUM_ROUNDS = AES128_NUM_ROUNDS
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         load_i,
    input  logic [127:0] key_i,
    input  logic         next_i,
    output logic [127:0] round_key_o,
    output logic [3:0]   round_o,
    output logic         busy_o,
    output logic         done_o
);

    ks_state_t   state;
    logic [1:0]  cnt;
    logic [7:0]  rcon;
    logic [31:0] temp;

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] rot;
    logic [31:0] t;
    logic [31:0] w4, w5, w6, w7;
    logic [7:0]  sub_in;
    logic [7:0]  sub_out;

    assign w0 = round_key_o[127:96];
    assign w1 = round_key_o[95:64];
    assign w2 = round_key_o[63:32];
    assign w3 = round_key_o[31:0];

    // RotWord of the last word; SubWord is applied one byte per SUB cycle.
    assign rot = {w3[23:0], w3[31:24]};

    always_comb begin
        sub_in = rot[31:24];
        unique case (cnt)
            2'd0: sub_in = rot[31:24];
            2'd1: sub_in = rot[23:16];
            2'd2: sub_in = rot[15:8];
            2'd3: sub_in = rot[7:0];
            default: sub_in = rot[31:24];
        endcase
    end

    aes128_sbox u_sbox (
        .in_byte  (sub_in),
        .out_byte (sub_out)
    );

    assign t  = temp ^ {rcon, 24'h0};
    assign w4 = w0 ^ t;
    assign w5 = w1 ^ w4;
    assign w6 = w2 ^ w5;
    assign w7 = w3 ^ w6;

    assign busy_o = (state != IDLE);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state       <= IDLE;
            cnt         <= 2'd0;
            rcon        <= RCON_INIT;
            temp        <= 32'h0;
            round_key_o <= 128'h0;
            round_o     <= 4'd0;
            done_o      <= 1'b0;
        end else begin
            done_o <= 1'b0;
            if (load_i) begin
                // Load also aborts any expansion in flight; a coincident next_i is dropped.
                state       <= IDLE;
                cnt         <= 2'd0;
                rcon        <= RCON_INIT;
                round_key_o <= key_i;
                round_o     <= 4'd0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (next_i && (round_o < 4'(NUM_ROUNDS))) begin
                            state <= SUB;
                            cnt   <= 2'd0;
                        end
                    end
                    SUB: begin
                        unique case (cnt)
                            2'd0: temp[31:24] <= sub_out;
                            2'd1: temp[23:16] <= sub_out;
                            2'd2: temp[15:8]  <= sub_out;
                            2'd3: temp[7:0]   <= sub_out;
                            default: temp[31:24] <= sub_out;
                        endcase
                        cnt <= cnt + 2'd1;
                        if (cnt == 2'd3) begin
                            state <= EXPAND;
                        end
                    end
                    EXPAND: begin
                        round_key_o <= {w4, w5, w6, w7};
                        round_o     <= round_o + 4'd1;
                        rcon        <= xtime(rcon);
                        done_o      <= 1'b1;
                        state       <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_aes128_key_schedule.sv
module tb_aes128_key_schedule;

    logic         clk_i = 1'b0;
    logic         rst_n_i;
    logic         load_i;
    logic [127:0] key_i;
    logic         next_i;
    logic [127:0] round_key_o;
    logic [3:0]   round_o;
    logic         busy_o;
    logic         done_o;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk_i = ~clk_i;

    aes128_key_schedule #(.NUM_ROUNDS(10)) dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .load_i      (load_i),
        .key_i       (key_i),
        .next_i      (next_i),
        .round_key_o (round_key_o),
        .round_o     (round_o),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    // Reference tables derived from GF(2^8) arithmetic, not copied from the design.
    logic [7:0] sb [256];
    logic [7:0] rc_tab [10];

    // Transaction-level model state.
    logic [127:0] m_key;
    int           m_round;
    int           m_left;
    logic         m_done;

    int done_seen;
    int busy_seen;

    localparam logic [127:0] KEY_A1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KEY_SEQ = 128'h000102030405060708090a0b0c0d0e0f;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        logic [15:0] d = {v, v};
        return d[15-n -: 8];
    endfunction

    task automatic build_tables();
        for (int a = 0; a < 256; a++) begin
            logic [7:0] inv = 8'h00;
            logic [7:0] av  = 8'(a);
            if (a != 0) begin
                for (int b = 1; b < 256; b++) begin
                    if (gmul(av, 8'(b)) == 8'h01) inv = 8'(b);
                end
            end
            sb[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
        rc_tab[0] = 8'h01;
        for (int i = 1; i < 10; i++) rc_tab[i] = gmul(rc_tab[i-1], 8'h02);
    endtask

    // One step of the FIPS-197 key expansion, word by word.
    function automatic logic [127:0] ks_next(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w [4];
        logic [31:0] t;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        t = {w[3][23:0], w[3][31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
        w[0] = w[0] ^ t;
        w[1] = w[1] ^ w[0];
        w[2] = w[2] ^ w[1];
        w[3] = w[3] ^ w[2];
        return {w[0], w[1], w[2], w[3]};
    endfunction

    task automatic model_reset();
        m_key   = '0;
        m_round = 0;
        m_left  = 0;
        m_done  = 1'b0;
    endtask

    // Drive one cycle of inputs, advance the model at the edge, compare just after it.
    task automatic step(input logic ld, input logic nx, input logic [127:0] k);
        load_i = ld;
        next_i = nx;
        key_i  = k;
        @(posedge clk_i);
        m_done = 1'b0;
        if (ld) begin
            m_key   = k;
            m_round = 0;
            m_left  = 0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_key  = ks_next(m_key, rc_tab[m_round]);
                m_round++;
                m_done = 1'b1;
            end
        end else if (nx && m_round < 10) begin
            m_left = 5;
        end
        #1;
        if (done_o) done_seen++;
        if (busy_o) busy_seen++;
        chk("round_key", round_key_o, m_key);
        chk("round", 128'(round_o), 128'(m_round));
        chk("done", 128'(done_o), 128'(m_done));
        chk("busy", 128'(busy_o), 128'(m_left > 0));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0);
    endtask

    initial begin
        build_tables();
        model_reset();
        rst_n_i = 1'b0;
        load_i  = 1'b0;
        next_i  = 1'b0;
        key_i   = '0;
        done_seen = 0;
        busy_seen = 0;

        // Reset state
        #12;
        chk("rst_key", round_key_o, 128'h0);
        chk("rst_round", 128'(round_o), 128'd0);
        chk("rst_done", 128'(done_o), 128'd0);
        chk("rst_busy", 128'(busy_o), 128'd0);
        @(posedge clk_i);
        #1;
        rst_n_i = 1'b1;

        // FIPS-197 A.1 load
        step(1'b1, 1'b0, KEY_A1);
        chk("a1_load", round_key_o, KEY_A1);

        // Single step: 5 busy cycles, done on the 6th edge
        done_seen = 0;
        busy_seen = 0;
        step(1'b0, 1'b1, '0);
        idle(4);
        chk("a1_r1_early_done", 128'(done_seen), 128'd0);
        idle(1);
        chk("a1_busy_cycles", 128'(busy_seen), 128'd5);
        chk("a1_r1_done", 128'(done_o), 128'd1);
        chk("a1_r1_key", round_key_o, 128'ha0fafe1788542cb123a339392a6c7605);
        idle(1);
        chk("a1_done_width", 128'(done_o), 128'd0);

        step(1'b0, 1'b1, '0);
        idle(6);
        chk("a1_r2_key", round_key_o, 128'hf2c295f27a96b9435935807a7359f67f);
        chk("a1_r2_round", 128'(round_o), 128'd2);

        // Full schedule: remaining rounds, then one request past the end
        done_seen = 0;
        for (int r = 2; r < 10; r++) begin
            step(1'b0, 1'b1, '0);
            idle(7);
        end
        chk("a1_r10_key", round_key_o, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        chk("a1_r10_round", 128'(round_o), 128'd10);
        chk("a1_r10_dones", 128'(done_seen), 128'd8);
        done_seen = 0;
        step(1'b0, 1'b1, '0);
        idle(8);
        chk("a1_past_end_done", 128'(done_seen), 128'd0);
        chk("a1_past_end_key", round_key_o, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        // next_i held high for 20 cycles
        step(1'b1, 1'b0, KEY_A1);
        done_seen = 0;
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, '0);
        chk("hold_dones", 128'(done_seen), 128'd3);
        idle(8);
        chk("hold_round", 128'(round_o), 128'd4);

        // Abort with load while SUB cnt=2
        step(1'b1, 1'b0, KEY_A1);
        done_seen = 0;
        step(1'b0, 1'b1, '0);
        idle(2);
        step(1'b1, 1'b0, KEY_SEQ);
        chk("abort_busy", 128'(busy_o), 128'd0);
        chk("abort_round", 128'(round_o), 128'd0);
        idle(6);
        chk("abort_dones", 128'(done_seen), 128'd0);
        step(1'b0, 1'b1, '0);
        idle(5);
        chk("seq_r1_key", round_key_o, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe);

        // Load with next in the same cycle: next is dropped
        step(1'b1, 1'b1, KEY_A1);
        chk("ld_nx_busy", 128'(busy_o), 128'd0);
        idle(2);

        // Async reset mid-EXPAND, between clock edges
        step(1'b0, 1'b1, '0);
        idle(4);
        #2;
        rst_n_i = 1'b0;
        #1;
        model_reset();
        chk("arst_key", round_key_o, 128'h0);
        chk("arst_round", 128'(round_o), 128'd0);
        chk("arst_busy", 128'(busy_o), 128'd0);
        chk("arst_done", 128'(done_o), 128'd0);
        #2;
        rst_n_i = 1'b1;
        @(posedge clk_i);
        #1;
        chk("arst_hold_key", round_key_o, 128'h0);
        step(1'b0, 1'b1, '0);
        idle(5);
        chk("zero_r1_key", round_key_o, 128'h62636363626363636263636362636363);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            logic ld;
            logic nx;
            ld = ($urandom_range(0, 24) == 0);
            nx = ($urandom_range(0, 2) == 0);
            step(ld, nx, {$urandom, $urandom, $urandom, $urandom});
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
